// File: rtl/fp_mult_seq.sv
// Sequential floating-point multiplier: shift-add mantissa datapath behind a start/busy/done handshake.
// Define FP_MULT_ROUND_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_mult_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [EXP_W+MAN_W:0]       f_1,
  input  logic [EXP_W+MAN_W:0]       f_2,
  output logic                       busy,
  output logic                       done,
  output logic                       f_nan,
  output logic                       f_inf,
  output logic [EXP_W+MAN_W:0]       s
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned CW = $clog2(MW + 1);
  localparam logic [EW-1:0]      BIAS_E = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic [EW-2:0]      EMAX   = (EW-1)'(2 ** EXP_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] NORM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state, next;
  logic [CW-1:0]    cnt;
  logic [MW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic             sign_r;
  logic [EW-1:0]    exp_r;
  logic             sp_nan, sp_inf, sp_zero;

  // Operand classification at accept time
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea     = f_1[W-2 -: EXP_W];
  assign eb     = f_2[W-2 -: EXP_W];
  assign fa     = f_1[MAN_W-1:0];
  assign fb     = f_2[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  // One shift-add step: multiplier bits sit in the low half of prod and shift out as the product grows
  logic [MW:0]   psum;
  logic [PW-1:0] prod_nxt;
  assign psum     = {1'b0, prod[PW-1:MW]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nxt = {psum, prod[MW-1:1]};

  // Normalise and round from the completed product
  logic [MAN_W-1:0] frac;
  logic             rnd_up;
  logic [MAN_W:0]   frac_rnd;
  logic [EW-1:0]    e_f;
  logic             ovf, unf;

  assign frac = prod[PW-1] ? prod[PW-2:MW] : prod[PW-3:MW-1];
`ifdef FP_MULT_ROUND_EN
  logic guard, sticky;
  assign guard  = prod[PW-1] ? prod[MW-1] : prod[MW-2];
  assign sticky = prod[PW-1] ? (|prod[MW-2:0]) : (|prod[MW-3:0]);
  assign rnd_up = guard && (sticky || frac[0]);
`else
  assign rnd_up = 1'b0;
`endif
  assign frac_rnd = {1'b0, frac} + (MAN_W+1)'(rnd_up);
  assign e_f      = exp_r + EW'(prod[PW-1]) + EW'(frac_rnd[MAN_W]);
  assign ovf      = !e_f[EW-1] && (e_f[EW-2:0] >= EMAX);
  assign unf      = e_f[EW-1] || (e_f == '0);

  logic [W-1:0] res_s;
  logic         res_nan, res_inf;

  always_comb begin
    res_s   = {sign_r, e_f[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
    res_nan = 1'b0;
    res_inf = 1'b0;
    if (sp_nan) begin
      res_s   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      res_nan = 1'b1;
    end else if (sp_inf || (!sp_zero && ovf)) begin
      res_s   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_inf = 1'b1;
    end else if (sp_zero || unf) begin
      res_s   = {sign_r, {(W-1){1'b0}}};
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = MULT;
      MULT:    if (cnt == CW'(MAN_W)) next = NORM;
      NORM:    next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      sign_r  <= 1'b0;
      exp_r   <= '0;
      sp_nan  <= 1'b0;
      sp_inf  <= 1'b0;
      sp_zero <= 1'b0;
      s       <= '0;
      f_nan   <= 1'b0;
      f_inf   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (next != IDLE);
      done <= (next == DONE);
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          mcand   <= {1'b1, fa};
          prod    <= {{MW{1'b0}}, 1'b1, fb};
          sign_r  <= f_1[W-1] ^ f_2[W-1];
          exp_r   <= EW'(ea) + EW'(eb) - BIAS_E;
          sp_nan  <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
          sp_inf  <= a_inf || b_inf;
          sp_zero <= a_zero || b_zero;
        end
        MULT: begin
          prod <= prod_nxt;
          cnt  <= cnt + CW'(1);
        end
        NORM: begin
          s     <= res_s;
          f_nan <= res_nan;
          f_inf <= res_inf;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/fp_mult_seq.md
# fp_mult_seq

Parametrised, sequential IEEE-754-style floating-point multiplier. It is the clocked successor to the team's combinational single-precision multiplier and adds:

- configurable exponent and mantissa widths;
- an iterative shift-add mantissa datapath;
- a start/busy/done handshake;
- optional round-to-nearest-even.

It sits between operand registers and the result bus of the FP arithmetic unit.

## Interface
Parameters:
- EXP_W, 8, exponent field width (BIAS = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- f_1  input  W  operand A, captured on the accepting edge
- f_2  input  W  operand B, captured on the accepting edge
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; s and the flags are valid from this cycle on
- f_nan  output  1  result is NaN
- f_inf  output  1  result is ±infinity (operand inf or overflow)
- s  output  W  product

## Operation
- FSM states and transitions:
  - IDLE: goes to MULT on start. f_1 and f_2 are registered. The sign is computed as XOR of the operand signs. Special cases are classified here.
  - MULT: MAN_W+1 iterations of shift-add over the hidden-bit-extended mantissas, one iteration per cycle. The product is 2*MAN_W+2 bits.
  - NORM: one cycle. Normalise, round or truncate, check range, register s and the flags.
  - DONE: done=1 for one cycle, then IDLE.
- Special cases always traverse all states; the datapath result is overridden in NORM.
- Exponent field 0 is treated as zero; subnormals are flushed.
- Special-case priority:
  1. Either operand NaN, or inf×0: s = canonical NaN (sign 0, exp all ones, fraction MSB 1, rest 0), f_nan=1.
  2. Either operand inf: s = signed inf, f_inf=1.
  3. Either operand zero: s = signed zero.
- Normal path:
  - Biased exponent e = ea + eb − BIAS, computed in EXP_W+2 signed bits.
  - If product bit 2*MAN_W+1 is set, shift right by 1 and set e = e+1.
  - Rounding carry-out renormalises and increments e.
  - If e ≥ 2^EXP_W−1: overflow, s = signed inf, f_inf=1.
  - If e ≤ 0: underflow, s = signed zero, no flag.
- start is ignored while busy=1, including in DONE.
- s, f_nan and f_inf hold their values until the NORM of the next operation.

## Timing
- Reset values: state IDLE, busy=0, done=0, f_nan=0, f_inf=0, s=0, iteration counter 0.
- Accepting edge E0 = the edge where start=1 in IDLE. busy rises after E0.
- MULT occupies edges E1..E(MAN_W+1). NORM registers the result at E(MAN_W+2).
- done is high in the cycle after E(MAN_W+2); busy is still 1 in that cycle. This is 25 cycles for the defaults.
- Latency is fixed and independent of operand values, special cases included.
- Earliest next accept: start held high is accepted at the edge that returns the FSM to IDLE+1, i.e. one idle cycle between done and the next acceptance.
- Reset asserted mid-operation clears everything immediately. No done is produced for the aborted operation.

## Configuration
- FP_MULT_ROUND_EN defined: round-to-nearest-even using guard, round and sticky bits from the discarded product bits. A tie rounds to even. A mantissa carry-out increments the exponent and may produce overflow to inf.
- FP_MULT_ROUND_EN undefined: truncation (round toward zero). Discarded bits are dropped, which matches the previous combinational block.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0) -> done at cycle 25 after accept; s=0x40C00000, f_nan=0, f_inf=0.
- 0x3F800001 × 0x3FC00000 (tie case) -> s=0x3FC00002 with FP_MULT_ROUND_EN, s=0x3FC00001 without.
- 0x7F800000 × 0x00000000 -> s=0x7FC00000, f_nan=1, f_inf=0; 0xFF800000 × 0x40000000 -> s=0xFF800000, f_inf=1.
- 0x7F000000 × 0x40000000 (overflow) -> s=0x7F800000, f_inf=1; 0x00800000 × 0x00800000 (underflow) -> s=0x00000000.
- Start pulsed again at cycle 10 of an operation -> ignored; first result unchanged, and exactly one done pulse.
- rst_n driven low at cycle 12 of an operation -> busy=0, s=0 immediately; no done. A new 0x3FC00000 × 0x3FC00000 afterwards -> s=0x40100000.
- Parameter case EXP_W=5, MAN_W=10: 0x4000 × 0x4200 -> done at cycle 12, s=0x4600.
